video_pattern_checker: RTL and testbench

Receive-side counterpart of the colour-bar test pattern generator. It sits on a video input path, such as a loopback from a video output, capture front end or deserializer. It samples vsync, den and pixel data on the pixel clock and measures active width, active height and frame period. Each active pixel is checked against the 16-bar reference pattern, and per-frame results plus a lock indication go to status registers and the bring-up logic.

---
 rtl/video_pattern_checker_if.sv | 13 +
 rtl/video_pattern_checker.sv | 220 ++++++++++++++++++++++
 tb/tb_video_pattern_checker.sv | 336 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/video_pattern_checker_if.sv
// Video input bus for the pattern checker.
//   video_vsync : vertical sync, polarity set by the checker's video_vsync_pol
//   video_den   : data enable, high on active pixels
//   video_pixel : RGB888 {R,G,B}, valid while video_den is high
// master drives the bus (source / testbench), slave samples it (checker).
interface video_pattern_checker_if;
  logic        video_vsync;
  logic        video_den;
  logic [23:0] video_pixel;

  modport master (output video_vsync, video_den, video_pixel);
  modport slave  (input  video_vsync, video_den, video_pixel);
endinterface

// File: rtl/video_pattern_checker.sv
// Receive-side checker for the 16-bar colour test pattern.
// Measures active width, line count and vsync period for each frame.
// Compares every active pixel against the bar colour for its x position.
// Publishes the results on each vsync leading edge and tracks lock.
//
// Ports
//   pixel_clock      : sole clock, rising edge
//   reset            : asynchronous, active-high; clears all state
//   vid (slave)      : video_vsync / video_den / video_pixel input bus
//   frame_done       : one-cycle pulse, published outputs just updated
//   frame_ok         : last published frame had no error of any kind
//   frame_err_count  : pixel mismatches in last frame (saturating)
//   measured_width   : den-high length of the last line of last frame
//   measured_height  : lines in last frame (saturating)
//   measured_period  : clocks between vsync leading edges (saturating)
//   locked           : lock_frames consecutive good frames, no bad since
module video_pattern_checker #(
  parameter int video_h_visible = 640,
  parameter int video_v_visible = 480,
  parameter bit video_vsync_pol = 1'b0,
  parameter int lock_frames     = 2
) (
  input  logic                   pixel_clock,
  input  logic                   reset,
  video_pattern_checker_if.slave vid,
  output logic                   frame_done,
  output logic                   frame_ok,
  output logic [15:0]            frame_err_count,
  output logic [13:0]            measured_width,
  output logic [13:0]            measured_height,
  output logic [23:0]            measured_period,
  output logic                   locked
);

  localparam logic [15:0] H_ACC  = 16'(video_h_visible);
  localparam logic [13:0] H_LEN  = 14'(video_h_visible);
  localparam logic [13:0] V_LEN  = 14'(video_v_visible);
  localparam logic [3:0]  LOCK_N = 4'(lock_frames);

  function automatic logic [23:0] bar_rgb(input logic [3:0] b);
    case (b)
      4'd0:    bar_rgb = 24'hFF0000;
      4'd1:    bar_rgb = 24'h00FF00;
      4'd2:    bar_rgb = 24'h0000FF;
      4'd3:    bar_rgb = 24'hFFFFFF;
      4'd4:    bar_rgb = 24'hAA0000;
      4'd5:    bar_rgb = 24'h00AA00;
      4'd6:    bar_rgb = 24'h0000AA;
      4'd7:    bar_rgb = 24'hAAAAAA;
      4'd8:    bar_rgb = 24'h550000;
      4'd9:    bar_rgb = 24'h005500;
      4'd10:   bar_rgb = 24'h000055;
      4'd11:   bar_rgb = 24'h555555;
      4'd12:   bar_rgb = 24'hFFFF00;
      4'd13:   bar_rgb = 24'hFF00FF;
      4'd14:   bar_rgb = 24'h00FFFF;
      default: bar_rgb = 24'h000000;
    endcase
  endfunction

  typedef enum logic {S_IDLE, S_ACTIVE} state_t;
  state_t r_state, w_state_n;

  // input stage
  logic        r_vs, r_vs_d, r_den;
  logic [23:0] r_pix;
  logic        w_vs_edge, w_publish, w_active;

  // frame accumulation
  logic [13:0] r_x, r_lines, r_last_w;
  logic [15:0] r_acc, r_err;
  logic [3:0]  r_bar;
  logic        r_in_line, r_skip, r_len_err;
  logic [23:0] r_period;

  logic        w_rise, w_step, w_line_end, w_mis, w_len_err_n;
  logic [13:0] w_cur_x, w_x_n, w_lines_n, w_last_w_n;
  logic [15:0] w_cur_acc, w_acc_sum, w_acc_n, w_err_n;
  logic [3:0]  w_cur_bar, w_bar_n;

  // publish snapshot and pipeline valids: [0] snapshot taken, [1] frame_done
  logic [1:0]  r_vld_pipe;
  logic [13:0] r_s_width, r_s_height;
  logic [23:0] r_s_period;
  logic [15:0] r_s_err;
  logic        r_s_ok;
  logic [3:0]  r_good;

  // Vsync regs reset to the active level so that a sync already in
  // progress at reset release does not look like a leading edge.
  always_ff @(posedge pixel_clock or posedge reset) begin
    if (reset) begin
      r_vs   <= video_vsync_pol;
      r_vs_d <= video_vsync_pol;
      r_den  <= 1'b0;
      r_pix  <= '0;
    end else begin
      r_vs   <= vid.video_vsync;
      r_vs_d <= r_vs;
      r_den  <= vid.video_den;
      r_pix  <= vid.video_pixel;
    end
  end

  assign w_vs_edge = (r_vs == video_vsync_pol) && (r_vs_d != video_vsync_pol);

  // FSM: state register
  always_ff @(posedge pixel_clock or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_n;
  end

  // FSM: next state
  always_comb begin
    w_state_n = r_state;
    if (r_state == S_IDLE && w_vs_edge) w_state_n = S_ACTIVE;
  end

  // FSM: outputs
  always_comb begin
    w_active  = (r_state == S_ACTIVE);
    w_publish = (r_state == S_ACTIVE) && w_vs_edge;
  end

  // Per-cycle pixel/line step. A den rise restarts x/acc/bar at zero for
  // the current pixel; acc tracks (x*16) mod width so the bar index
  // advances exactly at floor(x*16/width) without a divider.
  always_comb begin
    w_rise      = r_den && !r_in_line && !r_skip;
    w_step      = r_den && !r_skip;
    w_line_end  = !r_den && r_in_line;
    w_cur_x     = w_rise ? 14'd0 : r_x;
    w_cur_acc   = w_rise ? 16'd0 : r_acc;
    w_cur_bar   = w_rise ? 4'd0  : r_bar;
    w_mis       = w_step && (r_pix != bar_rgb(w_cur_bar));
    w_acc_sum   = w_cur_acc + 16'd16;
    w_acc_n     = w_acc_sum;
    w_bar_n     = w_cur_bar;
    if (w_acc_sum >= H_ACC) begin
      w_acc_n = w_acc_sum - H_ACC;
      if (w_cur_bar != 4'd15) w_bar_n = w_cur_bar + 4'd1;
    end
    w_x_n       = (w_cur_x == 14'h3FFF) ? w_cur_x : w_cur_x + 14'd1;
    w_err_n     = (w_mis && r_err != 16'hFFFF) ? r_err + 16'd1 : r_err;
    w_lines_n   = (w_line_end && r_lines != 14'h3FFF) ? r_lines + 14'd1 : r_lines;
    w_last_w_n  = w_line_end ? r_x : r_last_w;
    w_len_err_n = r_len_err | (w_line_end && (r_x != H_LEN));
  end

  // Frame counters. On a vsync edge with den high the open line is dropped
  // and r_skip masks den until it has been seen low.
  always_ff @(posedge pixel_clock or posedge reset) begin
    if (reset) begin
      r_x <= '0; r_acc <= '0; r_bar <= '0; r_in_line <= 1'b0; r_skip <= 1'b0;
      r_lines <= '0; r_last_w <= '0; r_len_err <= 1'b0; r_err <= '0; r_period <= '0;
    end else if (w_vs_edge) begin
      r_x <= '0; r_acc <= '0; r_bar <= '0; r_in_line <= 1'b0; r_skip <= r_den;
      r_lines <= '0; r_last_w <= '0; r_len_err <= 1'b0; r_err <= '0;
      r_period <= 24'd1;
    end else if (w_active) begin
      if (w_step) begin
        r_x       <= w_x_n;
        r_acc     <= w_acc_n;
        r_bar     <= w_bar_n;
        r_in_line <= 1'b1;
      end else if (w_line_end) begin
        r_in_line <= 1'b0;
      end
      if (!r_den) r_skip <= 1'b0;
      r_lines   <= w_lines_n;
      r_last_w  <= w_last_w_n;
      r_len_err <= w_len_err_n;
      r_err     <= w_err_n;
      if (r_period != 24'hFFFFFF) r_period <= r_period + 24'd1;
    end
  end

  // Snapshot on the edge cycle. A line that ended on this very cycle still
  // belongs to the closing frame; a den-high pixel here belongs to neither.
  always_ff @(posedge pixel_clock or posedge reset) begin
    if (reset) begin
      r_vld_pipe <= '0;
      r_s_width  <= '0; r_s_height <= '0; r_s_period <= '0; r_s_err <= '0;
      r_s_ok     <= 1'b0;
    end else begin
      r_vld_pipe <= {r_vld_pipe[0], w_publish};
      if (w_publish) begin
        r_s_width  <= w_last_w_n;
        r_s_height <= w_lines_n;
        r_s_period <= r_period;
        r_s_err    <= r_err;
        r_s_ok     <= (r_err == 16'd0) && !w_len_err_n && !r_den && (w_lines_n == V_LEN);
      end
    end
  end

  // Published outputs and lock counter, updated together with frame_done.
  always_ff @(posedge pixel_clock or posedge reset) begin
    if (reset) begin
      frame_ok        <= 1'b0;
      frame_err_count <= '0;
      measured_width  <= '0;
      measured_height <= '0;
      measured_period <= '0;
      r_good          <= '0;
    end else if (r_vld_pipe[0]) begin
      frame_ok        <= r_s_ok;
      frame_err_count <= r_s_err;
      measured_width  <= r_s_width;
      measured_height <= r_s_height;
      measured_period <= r_s_period;
      if (!r_s_ok)                r_good <= '0;
      else if (r_good != LOCK_N)  r_good <= r_good + 4'd1;
    end
  end

  assign frame_done = r_vld_pipe[1];
  assign locked     = (r_good == LOCK_N);

endmodule

// File: tb/tb_video_pattern_checker.sv
// Self-checking bench for video_pattern_checker on a reduced raster
// (40 visible pixels, 5 visible lines) so that many frames fit in the run.
module tb_video_pattern_checker;
  localparam int H   = 40;
  localparam int V   = 5;
  localparam int LF  = 2;
  localparam int HT  = 42;
  localparam bit POL = 1'b1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  video_pattern_checker_if vif();
  logic        frame_done, frame_ok, locked;
  logic [15:0] frame_err_count;
  logic [13:0] mw, mh;
  logic [23:0] mp;

  video_pattern_checker #(
    .video_h_visible(H), .video_v_visible(V),
    .video_vsync_pol(POL), .lock_frames(LF)
  ) dut (
    .pixel_clock(clk), .reset(rst), .vid(vif),
    .frame_done(frame_done), .frame_ok(frame_ok),
    .frame_err_count(frame_err_count), .measured_width(mw),
    .measured_height(mh), .measured_period(mp), .locked(locked)
  );

  typedef struct {
    int nlines; int ht; int last_w; int mode; int bx; int by;
    bit tail; bit head; int rst_line;
  } frame_t;
  typedef struct { int w; int h; int period; int err; bit ok; } exp_t;

  logic [23:0] colors [16] = '{24'hFF0000, 24'h00FF00, 24'h0000FF, 24'hFFFFFF,
                               24'hAA0000, 24'h00AA00, 24'h0000AA, 24'hAAAAAA,
                               24'h550000, 24'h005500, 24'h000055, 24'h555555,
                               24'hFFFF00, 24'hFF00FF, 24'h00FFFF, 24'h000000};

  int          n_checks = 0, n_errors = 0;
  int          got_n = 0, got_idx = -1, cyc = 0, m_good = 0;
  logic [69:0] got_vec = '0;
  bit          rst_dirty = 1'b0;
  exp_t        pend;

  function automatic logic [23:0] ref_px(input int x);
    int b;
    b = (x * 16) / H;
    if (b > 15) b = 15;
    return colors[b];
  endfunction

  function automatic logic [69:0] outs();
    return {mw, mh, mp, frame_err_count, frame_ok, locked};
  endfunction

  function automatic logic [69:0] expv(input exp_t e, input bit lk);
    return {14'(e.w), 14'(e.h), 24'(e.period), 16'(e.err), e.ok, lk};
  endfunction

  function automatic frame_t mkf(input int nl, input int lw, input int mode);
    frame_t f;
    f.nlines = nl; f.ht = HT; f.last_w = lw; f.mode = mode;
    f.bx = 0; f.by = 0; f.tail = 1'b0; f.head = 1'b0; f.rst_line = -1;
    return f;
  endfunction

  function automatic int next_good(input bit ok, input int g);
    if (!ok) return 0;
    return (g < LF) ? g + 1 : LF;
  endfunction

  // Sample outputs, then drive one cycle of inputs (on the falling edge).
  task automatic tick(input bit vs, input bit den, input logic [23:0] pix, input bit r);
    @(negedge clk);
    if (frame_done === 1'b1) begin
      got_n++;
      got_idx = cyc;
      got_vec = outs();
    end
    if (rst === 1'b1 && {frame_done, outs()} !== 71'd0) rst_dirty = 1'b1;
    rst = r;
    vif.video_vsync = vs ? POL : ~POL;
    vif.video_den   = den;
    vif.video_pixel = pix;
    cyc++;
  endtask

  // One frame: 2 vsync lines, nlines active lines, 2 blank lines.
  // The expected result is built from the pixels actually sent.
  task automatic drive_frame(input frame_t f, output exp_t e);
    int tot, ay, wl;
    bit den, r;
    logic [23:0] pix;
    tot = f.nlines + 4;
    e.err = 0;
    cyc = 0;
    for (int y = 0; y < tot; y++) begin
      for (int c = 0; c < f.ht; c++) begin
        den = 1'b0; pix = 24'h0;
        r  = (y == f.rst_line) && (c < 3);
        ay = y - 2;
        wl = (ay == f.nlines - 1) ? f.last_w : H;
        if (f.head && y == 0 && c < 5) begin
          den = 1'b1; pix = 24'($urandom);
        end else if (ay >= 0 && ay < f.nlines && c < wl) begin
          den = 1'b1; pix = ref_px(c);
          case (f.mode)
            1: if (ay == f.by && c == f.bx) pix = 24'h000000;
            2: pix = 24'h123456;
            3: if ($urandom_range(63) == 0) pix = 24'($urandom);
            default: ;
          endcase
          if (pix !== ref_px(c)) e.err++;
        end else if (f.tail && y == tot - 1 && c >= f.ht - 3) begin
          den = 1'b1; pix = ref_px(c - (f.ht - 3));
        end
        tick(y < 2, den, pix, r);
      end
    end
    if (e.err > 65535) e.err = 65535;
    e.h = f.nlines;
    e.w = (f.nlines > 0) ? f.last_w : 0;
    e.period = tot * f.ht;
    e.ok = (e.err == 0) && (f.last_w == H) && !f.tail && (f.nlines == V);
  endtask

  task automatic test_reset();
    exp_t e;
    int n0;
    rst = 1'b1;
    rst_dirty = 1'b0;
    for (int i = 0; i < 4; i++) tick(1'b0, 1'b0, 24'h0, 1'b1);
    n_checks++;
    if (rst_dirty || {frame_done, outs()} !== 71'd0) begin
      n_errors++;
      $display("FAIL reset_outputs got %h want 0", {frame_done, outs()});
    end
    for (int i = 0; i < 6; i++) tick(1'b0, 1'b0, 24'h0, 1'b0);
    n0 = got_n;
    drive_frame(mkf(V, H, 0), e);
    n_checks++;
    if (got_n !== n0) begin
      n_errors++;
      $display("FAIL reset_arm_no_publish got %0d pulses want 0", got_n - n0);
    end
    m_good = 0;
    pend = e;
  endtask

  task automatic test_clean();
    exp_t e;
    int n0;
    for (int i = 0; i < 4; i++) begin
      n0 = got_n;
      drive_frame(mkf(V, H, 0), e);
      m_good = next_good(pend.ok, m_good);
      n_checks++;
      if (got_n !== n0 + 1 || got_idx !== 3) begin
        n_errors++;
        $display("FAIL clean_done%0d pulses %0d idx %0d want 1 / 3", i, got_n - n0, got_idx);
      end
      n_checks++;
      if (got_vec !== expv(pend, m_good == LF)) begin
        n_errors++;
        $display("FAIL clean_frame%0d got %h want %h", i, got_vec, expv(pend, m_good == LF));
      end
      pend = e;
    end
  endtask

  task automatic test_bad_pixel();
    exp_t e;
    frame_t f;
    int n0;
    for (int i = 0; i < 4; i++) begin
      f = mkf(V, H, (i == 0) ? 1 : 0);
      f.bx = 15; f.by = 3;
      n0 = got_n;
      drive_frame(f, e);
      m_good = next_good(pend.ok, m_good);
      n_checks++;
      if (got_n !== n0 + 1 || got_vec !== expv(pend, m_good == LF)) begin
        n_errors++;
        $display("FAIL bad_pixel%0d pulses %0d got %h want %h", i, got_n - n0, got_vec,
                 expv(pend, m_good == LF));
      end
      pend = e;
    end
  endtask

  task automatic test_short_line();
    exp_t e;
    int n0;
    for (int i = 0; i < 2; i++) begin
      n0 = got_n;
      drive_frame(mkf(V, (i == 0) ? H - 1 : H, 0), e);
      m_good = next_good(pend.ok, m_good);
      n_checks++;
      if (got_n !== n0 + 1 || got_vec !== expv(pend, m_good == LF)) begin
        n_errors++;
        $display("FAIL short_line%0d pulses %0d got %h want %h", i, got_n - n0, got_vec,
                 expv(pend, m_good == LF));
      end
      pend = e;
    end
  endtask

  task automatic test_random();
    exp_t e;
    int n0, nl, lw;
    for (int i = 0; i < 6; i++) begin
      nl = V + int'($urandom_range(1));
      lw = ($urandom_range(2) == 0) ? H - 1 - int'($urandom_range(5)) : H;
      n0 = got_n;
      drive_frame(mkf(nl, lw, ($urandom_range(1) == 0) ? 3 : 0), e);
      m_good = next_good(pend.ok, m_good);
      n_checks++;
      if (got_n !== n0 + 1 || got_vec !== expv(pend, m_good == LF)) begin
        n_errors++;
        $display("FAIL random%0d pulses %0d got %h want %h", i, got_n - n0, got_vec,
                 expv(pend, m_good == LF));
      end
      pend = e;
    end
  endtask

  // den held high from the end of one frame across the next vsync edge
  task automatic test_trunc();
    exp_t e;
    frame_t f;
    int n0;
    for (int i = 0; i < 3; i++) begin
      f = mkf(V, H, 0);
      f.tail = (i == 0);
      f.head = (i == 1);
      n0 = got_n;
      drive_frame(f, e);
      m_good = next_good(pend.ok, m_good);
      n_checks++;
      if (i == 1) begin
        if (got_n !== n0 + 1 || got_vec[1] !== 1'b0 || got_vec[1:0] !== {1'b0, m_good == LF}) begin
          n_errors++;
          $display("FAIL trunc_ok pulses %0d ok/locked %b want 00", got_n - n0, got_vec[1:0]);
        end
      end else if (got_n !== n0 + 1 || got_vec !== expv(pend, m_good == LF)) begin
        n_errors++;
        $display("FAIL trunc_frame%0d pulses %0d got %h want %h", i, got_n - n0, got_vec,
                 expv(pend, m_good == LF));
      end
      pend = e;
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    frame_t f;
    int n0;
    f = mkf(V, H, 0);
    f.rst_line = 4;
    rst_dirty = 1'b0;
    n0 = got_n;
    drive_frame(f, e);
    m_good = next_good(pend.ok, m_good);
    n_checks++;
    if (got_n !== n0 + 1 || got_vec !== expv(pend, m_good == LF)) begin
      n_errors++;
      $display("FAIL rstmid_prev pulses %0d got %h want %h", got_n - n0, got_vec,
               expv(pend, m_good == LF));
    end
    n_checks++;
    if (rst_dirty || outs() !== 70'd0) begin
      n_errors++;
      $display("FAIL rstmid_clear dirty %0d outs %h want 0", rst_dirty, outs());
    end
    m_good = 0;
    n0 = got_n;
    drive_frame(mkf(V, H, 0), e);
    n_checks++;
    if (got_n !== n0) begin
      n_errors++;
      $display("FAIL rstmid_arm pulses %0d want 0", got_n - n0);
    end
    pend = e;
    n0 = got_n;
    drive_frame(mkf(V, H, 0), e);
    m_good = next_good(pend.ok, m_good);
    n_checks++;
    if (got_n !== n0 + 1 || got_idx !== 3 || got_vec !== expv(pend, m_good == LF)) begin
      n_errors++;
      $display("FAIL rstmid_first pulses %0d idx %0d got %h want %h", got_n - n0, got_idx,
               got_vec, expv(pend, m_good == LF));
    end
    pend = e;
  endtask

  // 1639 lines x 40 pixels of a colour absent from the pattern
  task automatic test_saturate();
    exp_t e;
    frame_t f;
    int n0;
    for (int i = 0; i < 2; i++) begin
      f = mkf(1639, H, 2);
      f.ht = H + 1;
      n0 = got_n;
      drive_frame((i == 0) ? f : mkf(V, H, 0), e);
      m_good = next_good(pend.ok, m_good);
      n_checks++;
      if (got_n !== n0 + 1 || got_vec !== expv(pend, m_good == LF)) begin
        n_errors++;
        $display("FAIL saturate%0d pulses %0d got %h want %h", i, got_n - n0, got_vec,
                 expv(pend, m_good == LF));
      end
      pend = e;
    end
  endtask

  initial begin
    rst = 1'b1;
    vif.video_vsync = ~POL;
    vif.video_den   = 1'b0;
    vif.video_pixel = 24'h0;
    test_reset();
    test_clean();
    test_bad_pixel();
    test_short_line();
    test_random();
    test_trunc();
    test_reset_mid();
    test_saturate();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
